// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared types and gray-code step decoder for the quadrature counter
package quad_pkg;

    localparam int CNT_W_DEF = 11;

    typedef enum logic [1:0] {
        DEC_NONE = 2'd0,
        DEC_INC  = 2'd1,
        DEC_DEC  = 2'd2,
        DEC_ERR  = 2'd3
    } dec_e;

    // Position of an {A,B} code along the forward cycle 00>01>11>10
    function automatic logic [1:0] gray_pos(input logic [1:0] code);
        case (code)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic dec_e gray_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] d;
        d = gray_pos(cur) - gray_pos(prev);
        case (d)
            2'd0:    return DEC_NONE;
            2'd1:    return DEC_INC;
            2'd3:    return DEC_DEC;
            default: return DEC_ERR;
        endcase
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// rtl/quad_glitch_filter.sv - one-bit synchronizer plus stability-count glitch filter
module quad_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_bypass,
    input  logic i_raw,
    output logic o_filt
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_filt;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign o_filt = r_filt;

    // A new level is accepted only once it has differed for FILT_LEN full cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            if (i_bypass) begin
                r_filt <= w_sync;
                r_cnt  <= '0;
            end else if (w_sync == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILT_LEN)) begin
                r_filt <= w_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/quad_coder_counter.sv
// rtl/quad_coder_counter.sv - x4 quadrature decoder with wrapping position, preset and index homing
module quad_coder_counter
    import quad_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int CNT_MAX     = 2047,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int HOME_VAL    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             enc_z,
    input  logic             zero_en,
    input  logic             preset_load,
    input  logic [CNT_W-1:0] preset_val,
    input  logic             err_clr,
    output logic [CNT_W-1:0] coder,
    output logic             dir,
    output logic             step,
    output logic             index_seen,
    output logic             err
);

    localparam int              WARM   = SYNC_STAGES + FILT_LEN;
    localparam int              WARM_W = $clog2(WARM + 1);
    localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] L_HOME = CNT_W'(HOME_VAL);
    localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);

    logic [WARM_W-1:0] r_warm;
    logic [1:0]        r_ab_prev;
    logic              r_z_prev;
    logic [CNT_W-1:0]  r_coder;
    logic              r_dir;
    logic              r_step;
    logic              r_index;
    logic              r_err;

    logic              w_fa;
    logic              w_fb;
    logic              w_fz;
    logic              w_bypass;
    logic              w_active;
    logic              w_z_rise;
    logic [1:0]        w_ab;
    dec_e              w_dec;

    assign w_bypass = (r_warm != '0);
    assign w_active = ~w_bypass;
    assign w_ab     = {w_fa, w_fb};
    assign w_dec    = gray_step(r_ab_prev, w_ab);
    assign w_z_rise = w_active & w_fz & ~r_z_prev;

    quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
        .clk(clk), .rst(rst), .i_bypass(w_bypass), .i_raw(enc_a), .o_filt(w_fa)
    );
    quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
        .clk(clk), .rst(rst), .i_bypass(w_bypass), .i_raw(enc_b), .o_filt(w_fb)
    );
    quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_z (
        .clk(clk), .rst(rst), .i_bypass(w_bypass), .i_raw(enc_z), .o_filt(w_fz)
    );

    assign coder      = r_coder;
    assign dir        = r_dir;
    assign step       = r_step;
    assign index_seen = r_index;
    assign err        = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm    <= WARM_W'(WARM);
            r_ab_prev <= 2'b00;
            r_z_prev  <= 1'b0;
            r_coder   <= L_HOME;
            r_dir     <= 1'b0;
            r_step    <= 1'b0;
            r_index   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // History tracks the filters even during warm-up so the first live cycle sees no edge
            r_ab_prev <= w_ab;
            r_z_prev  <= w_fz;
            r_step    <= 1'b0;
            if (w_bypass) begin
                r_warm <= r_warm - WARM_W'(1);
            end
            if (w_z_rise) begin
                r_index <= 1'b1;
            end
            if (w_active && (w_dec == DEC_ERR)) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
            if (preset_load) begin
                r_coder <= (preset_val > L_MAX) ? L_MAX : preset_val;
            end else if (zero_en && w_z_rise) begin
                r_coder <= L_HOME;
            end else if (w_active && (w_dec == DEC_INC)) begin
                r_coder <= (r_coder == L_MAX) ? '0 : r_coder + L_ONE;
                r_dir   <= 1'b1;
                r_step  <= 1'b1;
            end else if (w_active && (w_dec == DEC_DEC)) begin
                r_coder <= (r_coder == '0) ? L_MAX : r_coder - L_ONE;
                r_dir   <= 1'b0;
                r_step  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_quad_coder_counter.sv
// tb/tb_quad_coder_counter.sv - self-checking bench for quad_coder_counter
module tb_quad_coder_counter;

    localparam int MODULO = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enc_a = 1'b0;
    logic        enc_b = 1'b0;
    logic        enc_z = 1'b0;
    logic        zero_en = 1'b0;
    logic        preset_load = 1'b0;
    logic [10:0] preset_val = '0;
    logic        err_clr = 1'b0;
    logic [10:0] coder;
    logic        dir;
    logic        step;
    logic        index_seen;
    logic        err;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int step_cnt = 0;
    int first_step_cyc = -1;
    bit arm_first = 1'b0;

    int exp_pos = 0;
    bit exp_dir = 1'b0;
    logic [1:0] ab = 2'b00;
    logic [1:0] fwd_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    quad_coder_counter dut (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
        .zero_en(zero_en), .preset_load(preset_load), .preset_val(preset_val),
        .err_clr(err_clr), .coder(coder), .dir(dir), .step(step),
        .index_seen(index_seen), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #2;
        if (step === 1'b1) begin
            step_cnt++;
            if (arm_first && first_step_cyc < 0) first_step_cyc = cyc;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Move one quadrature state along the encoder cycle and advance the model position
    task automatic drive_move(input bit up);
        int idx = 0;
        for (int i = 0; i < 4; i++) if (fwd_seq[i] == ab) idx = i;
        idx = up ? (idx + 1) % 4 : (idx + 3) % 4;
        ab = fwd_seq[idx];
        enc_a = ab[1];
        enc_b = ab[0];
        exp_pos = up ? (exp_pos + 1) % MODULO : (exp_pos + MODULO - 1) % MODULO;
        exp_dir = up;
    endtask

    task automatic move(input bit up);
        drive_move(up);
        wait_cyc(20);
    endtask

    task automatic do_preset(input int v);
        preset_val = 11'(v);
        preset_load = 1'b1;
        wait_cyc(1);
        preset_load = 1'b0;
        exp_pos = (v > MODULO - 1) ? MODULO - 1 : v;
    endtask

    task automatic test_reset;
        enc_a = 1'b1; enc_b = 1'b1; ab = 2'b11;
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        step_cnt = 0;
        wait_cyc(10);
        exp_pos = 0;
        n_checks++; if (coder !== 11'd0) begin n_errs++; $display("FAIL reset_coder got %0d want 0", coder); end
        n_checks++; if (step_cnt !== 0) begin n_errs++; $display("FAIL reset_steps got %0d want 0", step_cnt); end
        n_checks++; if (err !== 1'b0) begin n_errs++; $display("FAIL reset_err got %b want 0", err); end
        n_checks++; if (index_seen !== 1'b0) begin n_errs++; $display("FAIL reset_index got %b want 0", index_seen); end
        n_checks++; if (dir !== 1'b0) begin n_errs++; $display("FAIL reset_dir got %b want 0", dir); end
    endtask

    task automatic test_forward;
        int s0;
        int drive_cyc;
        s0 = step_cnt;
        first_step_cyc = -1;
        arm_first = 1'b1;
        drive_cyc = cyc;
        for (int i = 0; i < 8; i++) move(1'b1);
        arm_first = 1'b0;
        n_checks++; if (coder !== 11'(exp_pos) || exp_pos != 8) begin n_errs++; $display("FAIL fwd_coder got %0d want 8", coder); end
        n_checks++; if (dir !== 1'b1) begin n_errs++; $display("FAIL fwd_dir got %b want 1", dir); end
        n_checks++; if (step_cnt - s0 != 8) begin n_errs++; $display("FAIL fwd_steps got %0d want 8", step_cnt - s0); end
        n_checks++; if (first_step_cyc - (drive_cyc + 1) != 7) begin n_errs++; $display("FAIL fwd_latency got %0d want 7", first_step_cyc - (drive_cyc + 1)); end
    endtask

    task automatic test_wrap;
        do_preset(2047);
        wait_cyc(2);
        n_checks++; if (coder !== 11'd2047) begin n_errs++; $display("FAIL preset_load got %0d want 2047", coder); end
        move(1'b1);
        n_checks++; if (coder !== 11'(exp_pos) || exp_pos != 0) begin n_errs++; $display("FAIL wrap_up got %0d want 0", coder); end
        move(1'b0);
        move(1'b0);
        n_checks++; if (coder !== 11'(exp_pos) || exp_pos != 2046) begin n_errs++; $display("FAIL wrap_down got %0d want 2046", coder); end
        n_checks++; if (dir !== 1'b0) begin n_errs++; $display("FAIL wrap_dir got %b want 0", dir); end
    endtask

    task automatic test_glitch;
        int s0;
        s0 = step_cnt;
        enc_a = ~ab[1];
        wait_cyc(3);
        enc_a = ab[1];
        wait_cyc(20);
        n_checks++; if (coder !== 11'(exp_pos)) begin n_errs++; $display("FAIL glitch_coder got %0d want %0d", coder, exp_pos); end
        n_checks++; if (step_cnt != s0) begin n_errs++; $display("FAIL glitch_steps got %0d want 0", step_cnt - s0); end
        n_checks++; if (err !== 1'b0) begin n_errs++; $display("FAIL glitch_err got %b want 0", err); end
    endtask

    task automatic test_illegal;
        int s0;
        s0 = step_cnt;
        ab = ab ^ 2'b11;
        enc_a = ab[1]; enc_b = ab[0];
        wait_cyc(20);
        n_checks++; if (err !== 1'b1) begin n_errs++; $display("FAIL illegal_err got %b want 1", err); end
        n_checks++; if (coder !== 11'(exp_pos)) begin n_errs++; $display("FAIL illegal_coder got %0d want %0d", coder, exp_pos); end
        n_checks++; if (step_cnt != s0) begin n_errs++; $display("FAIL illegal_steps got %0d want 0", step_cnt - s0); end
        ab = ab ^ 2'b11;
        enc_a = ab[1]; enc_b = ab[0];
        wait_cyc(7);
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        wait_cyc(2);
        n_checks++; if (err !== 1'b1) begin n_errs++; $display("FAIL err_set_wins got %b want 1", err); end
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        wait_cyc(1);
        n_checks++; if (err !== 1'b0) begin n_errs++; $display("FAIL err_clr got %b want 0", err); end
    endtask

    task automatic test_home;
        int s0;
        do_preset(100);
        wait_cyc(3);
        zero_en = 1'b1;
        s0 = step_cnt;
        enc_z = 1'b1;
        drive_move(1'b1);
        wait_cyc(20);
        exp_pos = 0;
        n_checks++; if (coder !== 11'd0) begin n_errs++; $display("FAIL home_coder got %0d want 0", coder); end
        n_checks++; if (step_cnt != s0) begin n_errs++; $display("FAIL home_step got %0d want 0", step_cnt - s0); end
        n_checks++; if (index_seen !== 1'b1) begin n_errs++; $display("FAIL home_index got %b want 1", index_seen); end
        enc_z = 1'b0;
        wait_cyc(20);
        s0 = step_cnt;
        enc_z = 1'b1;
        drive_move(1'b1);
        wait_cyc(7);
        do_preset(55);
        wait_cyc(12);
        n_checks++; if (coder !== 11'd55) begin n_errs++; $display("FAIL preset_over_home got %0d want 55", coder); end
        n_checks++; if (step_cnt != s0) begin n_errs++; $display("FAIL preset_over_home_step got %0d want 0", step_cnt - s0); end
        enc_z = 1'b0;
        zero_en = 1'b0;
        wait_cyc(20);
    endtask

    task automatic test_random;
        int s0;
        int r;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do_preset($urandom_range(0, 2047));
                wait_cyc(3);
                n_checks++; if (coder !== 11'(exp_pos)) begin n_errs++; $display("FAIL rand_preset[%0d] got %0d want %0d", i, coder, exp_pos); end
            end else begin
                s0 = step_cnt;
                move(1'($urandom_range(0, 1)));
                n_checks++; if (coder !== 11'(exp_pos)) begin n_errs++; $display("FAIL rand_coder[%0d] got %0d want %0d", i, coder, exp_pos); end
                n_checks++; if (dir !== exp_dir) begin n_errs++; $display("FAIL rand_dir[%0d] got %b want %b", i, dir, exp_dir); end
                n_checks++; if (step_cnt - s0 != 1) begin n_errs++; $display("FAIL rand_step[%0d] got %0d want 1", i, step_cnt - s0); end
            end
        end
        n_checks++; if (err !== 1'b0) begin n_errs++; $display("FAIL rand_err got %b want 0", err); end
    endtask

    initial begin
        wait_cyc(1);
        test_reset;
        test_forward;
        test_wrap;
        test_glitch;
        test_illegal;
        test_home;
        test_random;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
